// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin N:1 arbitrating mux with registered output; define RR_ARB_MUX_FIXED_PRI_EN for fixed lowest-index priority
module rr_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic                   load_en;
    logic                   any_req;
    logic                   take;
    logic [SEL_W-1:0]       grant;
    logic [WIDTH-1:0]       ch_data [NUM_IN];

    // Unpack the flat input bus into per-channel words
    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // The output register may load when it is empty or being drained this cycle
    assign load_en = !out_valid || out_ready;

`ifdef RR_ARB_MUX_FIXED_PRI_EN

    // Fixed priority: lowest-indexed requester wins (scan downward so the last hit is the lowest)
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[SEL_W'(i)]) begin
                grant   = SEL_W'(i);
                any_req = 1'b1;
            end
        end
    end

`else

    logic [SEL_W-1:0] last_grant;

    // Round-robin: first requester found searching upward from the channel after last_grant
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx  = (int'(last_grant) + k) % NUM_IN;
            cand = SEL_W'(idx);
            if (!any_req && in_valid[cand]) begin
                grant   = cand;
                any_req = 1'b1;
            end
        end
    end

    // Search pointer moves only on an accepted input word; reset gives channel 0 first priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= SEL_W'(NUM_IN - 1);
        end else if (take) begin
            last_grant <= grant;
        end
    end

`endif

    // Accept only from the granted channel, and only when the output register can take a word
    always_comb begin
        in_ready = '0;
        if (!reset && load_en && any_req) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign take = |(in_valid & in_ready);

    // Output register: load on input transfer, otherwise drop the word once it is consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant];
            out_sel   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
